pause_dim_ctrl: RTL and testbench

Parametrised pause and screen-dim controller for arcade cores.
- Merges a user pause button, N external pause requesters (e.g. hiscore access) and OSD-open into one core pause signal.
- Runs a saturating idle timer while user-paused and drives a dim level that fades in stepwise at vertical-blank boundaries.
- Sits between the core's video outputs and arcade_video. It delays RGB, blanks and syncs through one pixel-enable stage and applies the dim as a per-channel right shift.

---
 rtl/pause_dim_ctrl_pkg.sv | 31 +++
 rtl/rgb_dim_stage.sv | 63 ++++++
 rtl/pause_dim_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pause_dim_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pause_dim_ctrl_pkg.sv
// Shared types and width helpers for the pause / screen-dim controller.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pause_dim_pkg;

  // Dim behaviour selected by the core's OSD menu; encoding 3 is reserved and acts as off.
  typedef enum logic [1:0] {
    DIM_OFF     = 2'd0,
    DIM_INSTANT = 2'd1,
    DIM_FADE    = 2'd2
  } dim_mode_e;

  // Dim sequencing states.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    DIMMING = 2'd2,
    DIMMED  = 2'd3
  } dim_state_e;

  // Bits needed to hold a shift amount in 0..max_shift.
  function automatic int level_w(input int max_shift);
    return (max_shift < 1) ? 1 : $clog2(max_shift + 1);
  endfunction

  // Bits needed for a frame counter that runs 0..step_frames-1.
  function automatic int frame_cnt_w(input int step_frames);
    return (step_frames <= 2) ? 1 : $clog2(step_frames);
  endfunction

endpackage

// File: rtl/rgb_dim_stage.sv
// Pixel output register: right-shifts each colour channel by the dim level and delays timing alongside.
// Latency: 1 ce_pix for RGB and hbl/vbl/hs/vs alike.
// Backpressure: none; with ce_pix low every output holds its last value.
module rgb_dim_stage #(
  parameter int CW  = 4,
  parameter int NCH = 3,
  parameter int LW  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ce_pix_i,
  input  logic [LW-1:0]     shift_i,
  input  logic [NCH*CW-1:0] rgb_i,
  input  logic              hbl_i,
  input  logic              vbl_i,
  input  logic              hs_i,
  input  logic              vs_i,
  output logic [NCH*CW-1:0] rgb_o,
  output logic              hbl_o,
  output logic              vbl_o,
  output logic              hs_o,
  output logic              vs_o
);

  logic [NCH*CW-1:0] rgb_d;
  logic [NCH*CW-1:0] rgb_q;
  logic              hbl_q;
  logic              vbl_q;
  logic              hs_q;
  logic              vs_q;

  // Logical right shift per channel; blanking is passed through untouched and never zeroes RGB.
  always_comb begin
    rgb_d = '0;
    for (int i = 0; i < NCH; i++) begin
      rgb_d[i*CW +: CW] = rgb_i[i*CW +: CW] >> shift_i;
    end
  end

  // Single pixel-enable register stage keeps RGB and timing aligned.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rgb_q <= '0;
      hbl_q <= 1'b0;
      vbl_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else if (ce_pix_i) begin
      rgb_q <= rgb_d;
      hbl_q <= hbl_i;
      vbl_q <= vbl_i;
      hs_q  <= hs_i;
      vs_q  <= vs_i;
    end
  end

  assign rgb_o = rgb_q;
  assign hbl_o = hbl_q;
  assign vbl_o = vbl_q;
  assign hs_o  = hs_q;
  assign vs_o  = vs_q;

endmodule

// File: rtl/pause_dim_ctrl.sv
// Merges user/external/OSD pause sources into one core pause and dims the picture after a long user pause.
// Latency: pause 1 cycle after its sources, user toggle 2 cycles after a button press, video 1 ce_pix.
// Backpressure: none; video holds while ce_pix is low, dim level only moves on vblank rising edges.
module pause_dim_ctrl
  import pause_dim_pkg::*;
#(
  parameter int CW          = 4,
  parameter int NCH         = 3,
  parameter int NREQ        = 2,
  parameter int TW          = 32,
  parameter int DIM_CYCLES  = 480000000,
  parameter int MAX_SHIFT   = 2,
  parameter int STEP_FRAMES = 8
) (
  input  logic                                clk_sys,
  input  logic                                reset,
  input  logic                                pause_btn,
  input  logic [NREQ-1:0]                     pause_req,
  input  logic                                osd_open,
  input  logic                                osd_pause_en,
  input  logic [1:0]                          dim_mode,
  input  logic                                ce_pix,
  input  logic [NCH*CW-1:0]                   rgb_in,
  input  logic                                hbl_in,
  input  logic                                vbl_in,
  input  logic                                hs_in,
  input  logic                                vs_in,
  output logic [NCH*CW-1:0]                   rgb_out,
  output logic                                hbl,
  output logic                                vbl,
  output logic                                hs,
  output logic                                vs,
  output logic                                pause,
  output logic                                user_paused,
  output logic [level_w(MAX_SHIFT)-1:0]       dim_level
);

  localparam int LW = level_w(MAX_SHIFT);
  localparam int FW = frame_cnt_w(STEP_FRAMES);

  localparam logic [TW-1:0] DIM_MAX    = TW'(DIM_CYCLES);
  localparam logic [LW-1:0] MAX_LVL    = LW'(MAX_SHIFT);
  localparam logic [FW-1:0] FCNT_LAST  = FW'(STEP_FRAMES - 1);

  logic          btn_q;
  logic          btn_prev_q;
  logic          btn_rise;
  logic          up_q;
  logic          up_d;
  logic          pause_q;
  logic          pause_d;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;
  dim_state_e    state_q;
  dim_state_e    state_d;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic [LW-1:0] level_inc;
  logic [FW-1:0] fcnt_q;
  logic [FW-1:0] fcnt_d;
  logic          vbl_prev_q;
  logic          vbl_rise;
  dim_mode_e     mode;
  logic          dim_active;

  assign mode       = dim_mode_e'(dim_mode);
  assign dim_active = (mode == DIM_INSTANT) || (mode == DIM_FADE);
  assign btn_rise   = btn_q & ~btn_prev_q;
  assign vbl_rise   = vbl_in & ~vbl_prev_q;
  assign level_inc  = level_q + 1'b1;

  // Button toggle and merged pause request; pause sees the registered toggle, so it trails by one cycle.
  always_comb begin
    up_d    = up_q ^ btn_rise;
    pause_d = up_q | (|pause_req) | (osd_open & osd_pause_en);
  end

  // Idle timer: counts only while user-paused, saturates, and clears on the same edge the toggle drops.
  always_comb begin
    timer_d = timer_q;
    if (!up_d) begin
      timer_d = '0;
    end else if (up_q && (timer_q != DIM_MAX)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  // Dim sequencer: level steps only on vblank rises; un-pausing overrides everything immediately.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: begin
        if (up_q) state_d = WAIT;
      end
      WAIT: begin
        if ((timer_q == DIM_MAX) && dim_active) state_d = DIMMING;
      end
      DIMMING: begin
        if (vbl_rise) begin
          if (!dim_active) begin
            level_d = '0;
            fcnt_d  = '0;
            state_d = WAIT;
          end else if (mode == DIM_INSTANT) begin
            level_d = MAX_LVL;
            state_d = DIMMED;
          end else begin
            // Step on the first edge of each STEP_FRAMES-edge group.
            if (fcnt_q == '0) begin
              level_d = level_inc;
              if (level_inc == MAX_LVL) state_d = DIMMED;
            end
            fcnt_d = (fcnt_q == FCNT_LAST) ? '0 : fcnt_q + 1'b1;
          end
        end
      end
      DIMMED: begin
        if (vbl_rise && !dim_active) begin
          level_d = '0;
          fcnt_d  = '0;
          state_d = WAIT;
        end
      end
      default: state_d = RUN;
    endcase
    if (!up_d) begin
      state_d = RUN;
      level_d = '0;
      fcnt_d  = '0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_q      <= 1'b0;
      btn_prev_q <= 1'b0;
      up_q       <= 1'b0;
      pause_q    <= 1'b0;
      timer_q    <= '0;
      state_q    <= RUN;
      level_q    <= '0;
      fcnt_q     <= '0;
      vbl_prev_q <= 1'b0;
    end else begin
      btn_q      <= pause_btn;
      btn_prev_q <= btn_q;
      up_q       <= up_d;
      pause_q    <= pause_d;
      timer_q    <= timer_d;
      state_q    <= state_d;
      level_q    <= level_d;
      fcnt_q     <= fcnt_d;
      vbl_prev_q <= vbl_in;
    end
  end

  assign pause       = pause_q;
  assign user_paused = up_q;
  assign dim_level   = level_q;

  rgb_dim_stage #(
    .CW  (CW),
    .NCH (NCH),
    .LW  (LW)
  ) u_dim_stage (
    .clk_i    (clk_sys),
    .reset_i  (reset),
    .ce_pix_i (ce_pix),
    .shift_i  (level_q),
    .rgb_i    (rgb_in),
    .hbl_i    (hbl_in),
    .vbl_i    (vbl_in),
    .hs_i     (hs_in),
    .vs_i     (vs_in),
    .rgb_o    (rgb_out),
    .hbl_o    (hbl),
    .vbl_o    (vbl),
    .hs_o     (hs),
    .vs_o     (vs)
  );

endmodule

// File: tb/tb_pause_dim_ctrl.sv
// Directed bench for pause_dim_ctrl with a short dim timeout and two-frame fade steps.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: ce_pix mostly held high; one hold window checks the ce_pix-low path.
module tb_pause_dim_ctrl;

  localparam int CW  = 4;
  localparam int NCH = 3;

  logic              clk_sys;
  logic              reset;
  logic              pause_btn;
  logic [1:0]        pause_req;
  logic              osd_open;
  logic              osd_pause_en;
  logic [1:0]        dim_mode;
  logic              ce_pix;
  logic [NCH*CW-1:0] rgb_in;
  logic              hbl_in;
  logic              vbl_in;
  logic              hs_in;
  logic              vs_in;
  logic [NCH*CW-1:0] rgb_out;
  logic              hbl;
  logic              vbl;
  logic              hs;
  logic              vs;
  logic              pause;
  logic              user_paused;
  logic [1:0]        dim_level;

  int n_cmp = 0;
  int n_err = 0;

  pause_dim_ctrl #(
    .CW          (CW),
    .NCH         (NCH),
    .NREQ        (2),
    .TW          (32),
    .DIM_CYCLES  (100),
    .MAX_SHIFT   (2),
    .STEP_FRAMES (2)
  ) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .pause_btn    (pause_btn),
    .pause_req    (pause_req),
    .osd_open     (osd_open),
    .osd_pause_en (osd_pause_en),
    .dim_mode     (dim_mode),
    .ce_pix       (ce_pix),
    .rgb_in       (rgb_in),
    .hbl_in       (hbl_in),
    .vbl_in       (vbl_in),
    .hs_in        (hs_in),
    .vs_in        (vs_in),
    .rgb_out      (rgb_out),
    .hbl          (hbl),
    .vbl          (vbl),
    .hs           (hs),
    .vs           (vs),
    .pause        (pause),
    .user_paused  (user_paused),
    .dim_level    (dim_level)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle vblank pulse followed by three cycles of active video.
  task automatic vbl_pulse();
    vbl_in = 1'b1;
    step(1);
    vbl_in = 1'b0;
    step(3);
  endtask

  initial begin
    reset        = 1'b1;
    pause_btn    = 1'b0;
    pause_req    = 2'b00;
    osd_open     = 1'b0;
    osd_pause_en = 1'b0;
    dim_mode     = 2'd0;
    ce_pix       = 1'b1;
    rgb_in       = 12'hF8C;
    hbl_in       = 1'b1;
    vbl_in       = 1'b0;
    hs_in        = 1'b1;
    vs_in        = 1'b0;

    // Reset state
    step(3);
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    chk("rst_hbl", 32'(hbl), 32'h0);
    chk("rst_pause", 32'(pause), 32'h0);
    chk("rst_user", 32'(user_paused), 32'h0);
    chk("rst_level", 32'(dim_level), 32'h0);

    // Video path: blanking does not zero RGB, ce_pix low holds everything
    reset = 1'b0;
    step(1);
    chk("vid_rgb", 32'(rgb_out), 32'hF8C);
    chk("vid_hbl", 32'(hbl), 32'h1);
    chk("vid_hs", 32'(hs), 32'h1);
    hbl_in = 1'b0; hs_in = 1'b0; vs_in = 1'b1; ce_pix = 1'b0; rgb_in = 12'h123;
    step(2);
    chk("hold_rgb", 32'(rgb_out), 32'hF8C);
    chk("hold_hbl", 32'(hbl), 32'h1);
    chk("hold_vs", 32'(vs), 32'h0);
    ce_pix = 1'b1;
    step(1);
    chk("ce_rgb", 32'(rgb_out), 32'h123);
    chk("ce_vs", 32'(vs), 32'h1);
    chk("ce_hbl", 32'(hbl), 32'h0);
    vs_in = 1'b0; rgb_in = 12'hF8C;
    step(1);

    // Button press held for 50 cycles toggles exactly once
    pause_btn = 1'b1;
    step(1);
    chk("btn_e1_user", 32'(user_paused), 32'h0);
    step(1);
    chk("btn_e2_user", 32'(user_paused), 32'h1);
    chk("btn_e2_pause", 32'(pause), 32'h0);
    step(1);
    chk("btn_e3_pause", 32'(pause), 32'h1);
    step(47);
    chk("btn_hold_user", 32'(user_paused), 32'h1);
    pause_btn = 1'b0;
    step(2);
    pause_btn = 1'b1;
    step(2);
    chk("btn2_user", 32'(user_paused), 32'h0);
    chk("btn2_timer", dut.timer_q, 32'h0);
    step(1);
    chk("btn2_pause", 32'(pause), 32'h0);
    pause_btn = 1'b0;
    step(2);

    // External request pulse of 5 cycles
    pause_req = 2'b10;
    step(1);
    chk("req_pause_on", 32'(pause), 32'h1);
    chk("req_timer", dut.timer_q, 32'h0);
    step(4);
    chk("req_pause_last", 32'(pause), 32'h1);
    pause_req = 2'b00;
    step(1);
    chk("req_pause_off", 32'(pause), 32'h0);
    chk("req_level", 32'(dim_level), 32'h0);
    step(2);

    // Instant dim: level jumps at the first vblank rise after the timeout
    dim_mode  = 2'd1;
    pause_btn = 1'b1;
    step(2);
    pause_btn = 1'b0;
    step(110);
    chk("m1_timer_sat", dut.timer_q, 32'd100);
    chk("m1_midframe_level", 32'(dim_level), 32'h0);
    chk("m1_midframe_rgb", 32'(rgb_out), 32'hF8C);
    vbl_in = 1'b1;
    step(1);
    chk("m1_vbl_level", 32'(dim_level), 32'h2);
    chk("m1_vbl_rgb_old", 32'(rgb_out), 32'hF8C);
    step(1);
    chk("m1_rgb", 32'(rgb_out), 32'h323);
    chk("m1_vbl_out", 32'(vbl), 32'h1);
    vbl_in = 1'b0;
    step(5);
    chk("m1_rgb_hold", 32'(rgb_out), 32'h323);

    // Un-pause while dimmed: level and timer drop with the toggle
    pause_btn = 1'b1;
    step(2);
    chk("undim_user", 32'(user_paused), 32'h0);
    chk("undim_level", 32'(dim_level), 32'h0);
    chk("undim_timer", dut.timer_q, 32'h0);
    step(1);
    chk("undim_rgb", 32'(rgb_out), 32'hF8C);
    pause_btn = 1'b0;
    step(2);

    // Fade: edge 1 -> level 1, edge 3 -> level 2, later edges hold
    dim_mode  = 2'd2;
    pause_btn = 1'b1;
    step(2);
    pause_btn = 1'b0;
    step(110);
    chk("m2_pre_level", 32'(dim_level), 32'h0);
    vbl_pulse();
    chk("m2_e1_level", 32'(dim_level), 32'h1);
    chk("m2_e1_rgb", 32'(rgb_out), 32'h746);
    step(20);
    chk("m2_e1_rgb_hold", 32'(rgb_out), 32'h746);
    vbl_pulse();
    chk("m2_e2_level", 32'(dim_level), 32'h1);
    vbl_pulse();
    chk("m2_e3_level", 32'(dim_level), 32'h2);
    chk("m2_e3_rgb", 32'(rgb_out), 32'h323);
    vbl_pulse();
    vbl_pulse();
    chk("m2_e5_level", 32'(dim_level), 32'h2);

    // Mode switched off while dimmed: undim waits for the next vblank rise
    dim_mode = 2'd0;
    step(5);
    chk("off_pre_level", 32'(dim_level), 32'h2);
    vbl_pulse();
    chk("off_level", 32'(dim_level), 32'h0);
    chk("off_rgb", 32'(rgb_out), 32'hF8C);

    // Re-enable fade, take one step, then reset mid-fade
    dim_mode = 2'd2;
    step(2);
    vbl_pulse();
    chk("refade_level", 32'(dim_level), 32'h1);
    reset = 1'b1;
    step(1);
    chk("midrst_rgb", 32'(rgb_out), 32'h0);
    chk("midrst_level", 32'(dim_level), 32'h0);
    chk("midrst_user", 32'(user_paused), 32'h0);
    chk("midrst_pause", 32'(pause), 32'h0);
    reset = 1'b0;
    step(1);
    chk("postrst_rgb", 32'(rgb_out), 32'hF8C);

    // OSD pause gating
    osd_open = 1'b1;
    osd_pause_en = 1'b0;
    step(2);
    chk("osd_noen_pause", 32'(pause), 32'h0);
    osd_pause_en = 1'b1;
    step(1);
    chk("osd_en_pause", 32'(pause), 32'h1);
    osd_open = 1'b0;
    step(1);
    chk("osd_close_pause", 32'(pause), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
